line_buffer_scheduler: RTL and testbench
========================================

LINE_BUFFER_SCHEDULER -- requirements
Module: line_buffer_scheduler

Interface
REQ-001 Parameter KERNEL_SIZE, default 3: window height/width K; the block schedules K+1 line buffers.
REQ-002 Parameter ROW_SIZE, default 28: pixels per image row.
REQ-003 Parameter IMG_ROWS, default 28: rows per frame; legal only if IMG_ROWS >= KERNEL_SIZE.
REQ-004 clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a frame when in IDLE, ignored otherwise.
REQ-007 data_in_valid  in  1  upstream pixel present this cycle.
REQ-008 out_ready  in  1  downstream can take a window this cycle.
REQ-009 in_ready  out  1  pixel accepted this cycle iff data_in_valid && in_ready.
REQ-010 wr_en  out  K+1  one-hot write enable to line buffer wr_ptr; combinational, equals accept ? onehot(wr_ptr) : 0.
REQ-011 rd_en  out  K+1  read enables; K bits set (all buffers except wr slot of oldest-free), combinational, gated by read_active && out_ready.
REQ-012 rd_top  out  clog2(K+1)  index of buffer holding the oldest (top) window row.
REQ-013 window_valid  out  1  registered; a complete KxK window is present at line-buffer outputs.
REQ-014 out_row, out_col  out  clog2(IMG_ROWS), clog2(ROW_SIZE)  registered coordinates of window top-left, valid with window_valid.
REQ-015 busy  out  1  high in any state except IDLE; frame_done  out  1  one-cycle pulse at frame end.

Function
REQ-016 States: IDLE, FILL, STREAM, DONE; encoding is free.
REQ-017 IDLE -> FILL on start; FILL -> STREAM when full_rows reaches K; STREAM -> DONE when all IMG_ROWS accepted, no read pass active, full_rows < K; DONE -> IDLE after exactly one cycle with frame_done=1.
REQ-018 Write side: wr_col counts accepted pixels 0..ROW_SIZE-1; on wrap, wr_ptr advances mod K+1, wr_row increments, full_rows increments.
REQ-019 in_ready = state in {FILL, STREAM} && full_rows <= K && wr_row < IMG_ROWS.
REQ-020 Read pass: starts when full_rows >= K and no pass active; rd_col counts 0..ROW_SIZE-1, advancing only when rd_en is nonzero (out_ready high).
REQ-021 rd_en asserts on the K buffers rd_top, rd_top+1, ..., rd_top+K-1 (mod K+1).
REQ-022 Pass end (rd_col = ROW_SIZE-1 with out_ready): rd_top advances mod K+1, full_rows decrements, out_row increments; if the updated full_rows >= K the next pass starts the following cycle with no gap.
REQ-023 Simultaneous write-row completion and pass end: full_rows unchanged, both pointers advance.
REQ-024 A pass is never started before full_rows >= K; a pass never stalls on input.
REQ-025 window_valid is high in the cycle after rd_en was nonzero with rd_col >= K-1; out_col = that rd_col - (K-1).
REQ-026 out_ready low: rd_en = 0, rd_col holds, window_valid = 0 next cycle; the writer continues while in_ready is high.
REQ-027 full_rows range 0..K+1; overflow/underflow is impossible by construction and is asserted in simulation.
REQ-028 Frame yields exactly (IMG_ROWS-K+1) x (ROW_SIZE-K+1) window_valid pulses.

Reset
REQ-029 reset high: state=IDLE; in_ready, wr_en, rd_en, window_valid, busy, frame_done = 0; wr_ptr, rd_top, all counters, full_rows = 0; takes effect immediately, regardless of clock.
REQ-030 Reset mid-frame abandons the frame; the next start begins a clean frame and no stale window_valid is emitted.

Verification
REQ-031 Defaults, start, data_in_valid=1, out_ready=1 throughout -> first rd_en 2 cycles after pixel 83 accepted; 676 window_valid pulses; frame_done exactly once; busy low after.
REQ-032 Same stream -> in_ready low for exactly one cycle in the frame (row 3 written while row 0's last column is read), never otherwise.
REQ-033 out_ready held low 50 cycles mid-pass -> rd_col frozen, in_ready falls once full_rows = 4, resumes with no lost or duplicated windows (still 676 total, out_col/out_row monotonic).
REQ-034 data_in_valid toggled 1/0 every cycle -> passes start only when full_rows >= 3; window count 676; rd_top sequence 0,1,2,3,0,...
REQ-035 reset asserted after 200 accepted pixels -> all outputs 0 same cycle; new start then produces a full correct 676-window frame.
REQ-036 start pulsed while busy -> ignored; K=2, IMG_ROWS=2 -> exactly 1 x (ROW_SIZE-1) windows, then frame_done.

Source files
------------

// File: rtl/line_buffer_scheduler_if.sv
// Handshake and status bundle between the line buffer scheduler and its neighbours.
// slave modport: the scheduler (takes start/data_in_valid/out_ready, drives the rest).
// master modport: upstream/downstream side that drives start, data_in_valid and out_ready.
interface line_buffer_scheduler_if #(
  parameter int KERNEL_SIZE = 3,
  parameter int ROW_SIZE    = 28,
  parameter int IMG_ROWS    = 28
);
  localparam int NB = KERNEL_SIZE + 1;
  localparam int PW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int RW = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;

  logic          start;
  logic          data_in_valid;
  logic          out_ready;
  logic          in_ready;
  logic [NB-1:0] wr_en;
  logic [NB-1:0] rd_en;
  logic [PW-1:0] rd_top;
  logic          window_valid;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          busy;
  logic          frame_done;

  modport master (
    output start, data_in_valid, out_ready,
    input  in_ready, wr_en, rd_en, rd_top, window_valid, out_row, out_col, busy, frame_done
  );

  modport slave (
    input  start, data_in_valid, out_ready,
    output in_ready, wr_en, rd_en, rd_top, window_valid, out_row, out_col, busy, frame_done
  );
endinterface

// File: rtl/line_buffer_scheduler.sv
// Schedules KERNEL_SIZE+1 line buffers: one row is written while the K others
// feed a KxK window, one read pass per output row.
// Ports: clock, reset (async, active-high), bus (slave modport): start,
// data_in_valid/in_ready pixel handshake, out_ready, wr_en/rd_en buffer enables,
// rd_top, window_valid with out_row/out_col, busy, frame_done.
module line_buffer_scheduler #(
  parameter int KERNEL_SIZE = 3,
  parameter int ROW_SIZE    = 28,
  parameter int IMG_ROWS    = 28
) (
  input logic clock,
  input logic reset,
  line_buffer_scheduler_if.slave bus
);
  localparam int K   = KERNEL_SIZE;
  localparam int NB  = K + 1;
  localparam int PW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW  = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int RW  = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
  localparam int WRW = $clog2(IMG_ROWS + 1);
  localparam int FW  = $clog2(K + 2);

  localparam logic [PW-1:0]  PTR_LAST  = PW'(K);
  localparam logic [CW-1:0]  COL_LAST  = CW'(ROW_SIZE - 1);
  localparam logic [CW-1:0]  COL_WIN0  = CW'(K - 1);
  localparam logic [WRW-1:0] ROWS_ALL  = WRW'(IMG_ROWS);
  localparam logic [FW-1:0]  FULL_K    = FW'(K);
  localparam logic [FW-1:0]  FULL_MAX  = FW'(K + 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t         state, state_next;
  logic [PW-1:0]  wr_ptr, rd_top;
  logic [CW-1:0]  wr_col, rd_col;
  logic [WRW-1:0] wr_row;
  logic [RW-1:0]  rd_row;
  logic [FW-1:0]  full_rows, full_rows_next;
  logic           read_active, read_active_next;
  logic           running, busy, frame_done;
  logic           in_ready, accept, row_written, rd_go, pass_end;
  logic [PW-1:0]  free_slot;
  logic [NB-1:0]  rd_mask, wr_onehot;
  logic           window_valid;
  logic [RW-1:0]  out_row;
  logic [CW-1:0]  out_col;

  // ---------------- FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    frame_done = 1'b0;
    running    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) state_next = FILL;
      end
      FILL: begin
        running = 1'b1;
        if (full_rows >= FULL_K) state_next = STREAM;
      end
      STREAM: begin
        running = 1'b1;
        if (wr_row == ROWS_ALL && !read_active && full_rows < FULL_K) state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- datapath control ----------------
  always_comb begin
    in_ready    = running && (full_rows <= FULL_K) && (wr_row < ROWS_ALL);
    accept      = bus.data_in_valid && in_ready;
    row_written = accept && (wr_col == COL_LAST);
    rd_go       = read_active && bus.out_ready;
    pass_end    = rd_go && (rd_col == COL_LAST);
    // The buffer just below rd_top (mod K+1) is the one the writer owns.
    free_slot   = (rd_top == '0) ? PTR_LAST : rd_top - 1'b1;
    wr_onehot   = NB'(1) << wr_ptr;
    rd_mask     = '0;
    for (int i = 0; i < NB; i++) rd_mask[i] = (PW'(i) != free_slot);

    full_rows_next = full_rows;
    if (row_written && !pass_end)      full_rows_next = full_rows + 1'b1;
    else if (pass_end && !row_written) full_rows_next = full_rows - 1'b1;

    // A finishing pass chains straight into the next one when enough rows are
    // already resident; otherwise a fresh pass waits for a registered full_rows >= K.
    read_active_next = read_active;
    if (pass_end)          read_active_next = (full_rows_next >= FULL_K);
    else if (!read_active) read_active_next = running && (full_rows >= FULL_K);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_top       <= '0;
      wr_col       <= '0;
      rd_col       <= '0;
      wr_row       <= '0;
      rd_row       <= '0;
      full_rows    <= '0;
      read_active  <= 1'b0;
      window_valid <= 1'b0;
      out_row      <= '0;
      out_col      <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        // Previous frame leaves wr_row/full_rows non-zero; start from scratch.
        wr_ptr      <= '0;
        rd_top      <= '0;
        wr_col      <= '0;
        rd_col      <= '0;
        wr_row      <= '0;
        rd_row      <= '0;
        full_rows   <= '0;
        read_active <= 1'b0;
      end else begin
        if (accept) begin
          if (wr_col == COL_LAST) begin
            wr_col <= '0;
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            wr_row <= wr_row + 1'b1;
          end else begin
            wr_col <= wr_col + 1'b1;
          end
        end
        if (rd_go) begin
          if (rd_col == COL_LAST) begin
            rd_col <= '0;
            rd_top <= (rd_top == PTR_LAST) ? '0 : rd_top + 1'b1;
            rd_row <= rd_row + 1'b1;
          end else begin
            rd_col <= rd_col + 1'b1;
          end
        end
        full_rows   <= full_rows_next;
        read_active <= read_active_next;
      end
      // Window is complete once K columns of the current pass have been read.
      window_valid <= rd_go && (rd_col >= COL_WIN0);
      if (rd_go) begin
        out_col <= rd_col - COL_WIN0;
        out_row <= rd_row;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(row_written && !pass_end && full_rows == FULL_MAX));
      assert (!(pass_end && !row_written && full_rows == '0));
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.wr_en        = accept ? wr_onehot : '0;
  assign bus.rd_en        = rd_go ? rd_mask : '0;
  assign bus.rd_top       = rd_top;
  assign bus.window_valid = window_valid;
  assign bus.out_row      = out_row;
  assign bus.out_col      = out_col;
  assign bus.busy         = busy;
  assign bus.frame_done   = frame_done;
endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Directed bench: default 3x3/28x28 scheduler through several traffic patterns
// plus a small K=2, 2-row instance, with bench-side window/pointer bookkeeping.
module tb_line_buffer_scheduler;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  line_buffer_scheduler_if #(.KERNEL_SIZE(3), .ROW_SIZE(28), .IMG_ROWS(28)) bus ();
  line_buffer_scheduler_if #(.KERNEL_SIZE(2), .ROW_SIZE(8),  .IMG_ROWS(2))  bus2 ();

  line_buffer_scheduler #(.KERNEL_SIZE(3), .ROW_SIZE(28), .IMG_ROWS(28)) dut (
    .clock(clock), .reset(reset), .bus(bus));
  line_buffer_scheduler #(.KERNEL_SIZE(2), .ROW_SIZE(8), .IMG_ROWS(2)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  logic [3:0] mask_tbl [4];
  int acc_cnt, win_cnt, done_cnt, irdy_low, passes, rd_total, px83, first_rd;
  int err_coord, err_wv, err_wr, err_mask, err_start, err_stall, last_stall_irdy;

  task automatic run_frame(input int mode, input string tag);
    int cyc, in_pass, stall_left, exp_top, exp_row, exp_col;
    bit exp_wv, done_seen, stall_used, aborted, dv, ordy, acc;
    logic [3:0] exp_wr;
    acc_cnt = 0; win_cnt = 0; done_cnt = 0; irdy_low = 0; passes = 0; rd_total = 0;
    px83 = -1; first_rd = -1; err_coord = 0; err_wv = 0; err_wr = 0; err_mask = 0;
    err_start = 0; err_stall = 0; last_stall_irdy = -1;
    cyc = 0; in_pass = 0; stall_left = 0; exp_top = 0; exp_row = 0; exp_col = 0;
    exp_wv = 0; done_seen = 0; stall_used = 0; aborted = 0;

    bus.data_in_valid = 1'b0; bus.out_ready = 1'b1; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    while (!done_seen && !aborted && cyc < 6000) begin
      dv   = (mode == 2) ? (cyc % 2 == 0) : 1'b1;
      ordy = (stall_left == 0);
      bus.data_in_valid = dv; bus.out_ready = ordy;
      #1;
      acc = dv && bus.in_ready;
      if (bus.window_valid !== exp_wv) err_wv++;
      if (bus.window_valid) begin
        if (int'(bus.out_row) != exp_row || int'(bus.out_col) != exp_col) err_coord++;
        win_cnt++;
        exp_col++;
        if (exp_col == 26) begin exp_col = 0; exp_row++; end
      end
      exp_wv = (bus.rd_en != 0) && (in_pass >= 2);
      exp_wr = acc ? (4'b0001 << ((acc_cnt / 28) % 4)) : 4'b0000;
      if (bus.wr_en !== exp_wr) err_wr++;
      if (bus.busy && !bus.in_ready && acc_cnt < 784) irdy_low++;
      if (!ordy && bus.rd_en != 0) err_stall++;
      if (stall_left == 1) last_stall_irdy = int'(bus.in_ready);
      if (bus.rd_en != 0) begin
        if (first_rd < 0) first_rd = cyc;
        if (acc_cnt / 28 - passes < 3) err_start++;
        if (bus.rd_en !== mask_tbl[exp_top] || bus.rd_top !== 2'(exp_top)) err_mask++;
        in_pass++; rd_total++;
        if (in_pass == 28) begin in_pass = 0; passes++; exp_top = (exp_top + 1) % 4; end
        if (mode == 1 && !stall_used && rd_total == 40) begin stall_left = 51; stall_used = 1; end
      end
      if (acc) begin
        if (acc_cnt == 83) px83 = cyc;
        acc_cnt++;
      end
      if (bus.frame_done) begin done_cnt++; done_seen = 1; end
      if (stall_left > 0) stall_left--;
      if (mode == 3 && acc_cnt == 200) aborted = 1;
      @(posedge clock); #1;
      cyc++;
    end

    if (aborted) begin
      bus.data_in_valid = 1'b1; bus.out_ready = 1'b1;
      #2 reset = 1'b1;
      #1;
      check({tag, " rst in_ready"}, int'(bus.in_ready), 0);
      check({tag, " rst wr_en"}, int'(bus.wr_en), 0);
      check({tag, " rst rd_en"}, int'(bus.rd_en), 0);
      check({tag, " rst window_valid"}, int'(bus.window_valid), 0);
      check({tag, " rst busy"}, int'(bus.busy), 0);
      check({tag, " rst rd_top"}, int'(bus.rd_top), 0);
      check({tag, " rst out_col"}, int'(bus.out_col), 0);
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;
      win_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        #1;
        if (bus.window_valid || bus.frame_done) win_cnt++;
        @(posedge clock); #1;
      end
      check({tag, " stale outputs after reset"}, win_cnt, 0);
    end else begin
      bus.data_in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        #1;
        if (bus.window_valid) win_cnt++;
        if (bus.frame_done) done_cnt++;
        @(posedge clock); #1;
      end
      check({tag, " windows"}, win_cnt, 676);
      check({tag, " frame_done count"}, done_cnt, 1);
      check({tag, " busy after"}, int'(bus.busy), 0);
      check({tag, " pixels accepted"}, acc_cnt, 784);
      check({tag, " passes"}, passes, 26);
      check({tag, " coord errors"}, err_coord, 0);
      check({tag, " window_valid timing errors"}, err_wv, 0);
      check({tag, " wr_en errors"}, err_wr, 0);
      check({tag, " rd_en/rd_top errors"}, err_mask, 0);
      check({tag, " early pass starts"}, err_start, 0);
      if (mode == 0) begin
        check({tag, " first rd_en latency"}, first_rd - px83, 2);
        check({tag, " in_ready low cycles"}, irdy_low, 1);
      end
      if (mode == 1) begin
        check({tag, " rd_en during stall"}, err_stall, 0);
        check({tag, " in_ready end of stall"}, last_stall_irdy, 0);
      end
    end
  endtask

  initial begin
    int win2, done2, err2, exp_col2;
    bit seen2;
    mask_tbl[0] = 4'b0111; mask_tbl[1] = 4'b1110;
    mask_tbl[2] = 4'b1101; mask_tbl[3] = 4'b1011;
    bus.start = 1'b0; bus.data_in_valid = 1'b0; bus.out_ready = 1'b0;
    bus2.start = 1'b0; bus2.data_in_valid = 1'b0; bus2.out_ready = 1'b0;

    @(posedge clock); #1;
    check("reset in_ready", int'(bus.in_ready), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset window_valid", int'(bus.window_valid), 0);
    check("reset rd_en", int'(bus.rd_en), 0);
    check("reset frame_done", int'(bus.frame_done), 0);
    check("reset rd_top", int'(bus.rd_top), 0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_frame(0, "stream");
    run_frame(1, "stall");
    run_frame(2, "toggle");
    run_frame(3, "abort");
    run_frame(0, "after_reset");

    // K=2, two rows: one pass of 7 windows; extra start pulses while busy are ignored.
    win2 = 0; done2 = 0; err2 = 0; exp_col2 = 0; seen2 = 0;
    bus2.out_ready = 1'b1; bus2.data_in_valid = 1'b0; bus2.start = 1'b1;
    @(posedge clock); #1;
    bus2.start = 1'b0;
    for (int c = 0; c < 200 && !seen2; c++) begin
      bus2.data_in_valid = 1'b1;
      bus2.start = (c == 5 || c == 20);
      #1;
      if (bus2.window_valid) begin
        if (bus2.out_row != 1'b0 || int'(bus2.out_col) != exp_col2) err2++;
        exp_col2++; win2++;
      end
      if (bus2.frame_done) begin done2++; seen2 = 1; end
      @(posedge clock); #1;
    end
    bus2.start = 1'b0; bus2.data_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus2.window_valid) win2++;
      if (bus2.frame_done) done2++;
      @(posedge clock); #1;
    end
    check("k2 windows", win2, 7);
    check("k2 frame_done count", done2, 1);
    check("k2 coord errors", err2, 0);
    check("k2 busy after", int'(bus2.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
